// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared types and widths for the FIFO write-port arbiter
package fifo_wr_arbiter_pkg;

    typedef enum logic {IDLE, BURST} state_t;

    localparam int ARB_OWN_W  = 2;
    localparam int ARB_BCNT_W = 5;
    localparam int STALL_W    = 16;

    function automatic int cnt_w(input int max_burst);
        return ($clog2(max_burst + 1) < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick: combinational round-robin picker starting after the last owner
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int OWN_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [OWN_W-1:0] last,
    output logic [OWN_W-1:0] nxt,
    output logic             found
);

    // scan from farthest to nearest so the nearest requester after last wins
    always_comb begin
        nxt   = last;
        found = |req;
        for (int k = NREQ; k >= 1; k--)
            if (req[(int'(last) + k) % NREQ]) nxt = OWN_W'((int'(last) + k) % NREQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter for the FIFO write port; FIFO_ARB_STALL_CNT_EN adds a stall counter
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int OWN_W     = $clog2(NREQ)
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       gnt,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_wr_data,
    output logic                  busy,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [STALL_W-1:0]    stall_cnt,
    input  logic                  stall_clr,
`endif
    output logic [OWN_W-1:0]      owner
);

    localparam int BCNT_W = cnt_w(MAX_BURST);

    state_t            state, state_nxt;
    logic [BCNT_W-1:0] beat_cnt;
    logic [OWN_W-1:0]  pick;
    logic              found, accept, last_beat;

    fifo_wr_arbiter_rr_pick #(.NREQ(NREQ), .OWN_W(OWN_W)) u_pick (
        .req   (req),
        .last  (owner),
        .nxt   (pick),
        .found (found)
    );

    // beat accept and zero-latency pass-through of the owner's data; reset masks the grant
    always_comb begin
        accept       = (state == BURST) && req[owner] && !fifo_full && !wr_rst;
        last_beat    = accept && (req_last[owner] ||
                       (MAX_BURST != 0 && beat_cnt == BCNT_W'(MAX_BURST - 1)));
        gnt          = accept ? NREQ'(1) << owner : '0;
        fifo_wr_en   = accept;
        fifo_wr_data = req_data[owner*WIDTH +: WIDTH];
        busy         = (state == BURST);
    end

    // next state: arbitrate in IDLE, leave BURST after the packet or burst cap
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = found ? BURST : IDLE;
        else               state_nxt = last_beat ? IDLE : BURST;
    end

    // state, owner and beat counter registers; counter saturates rather than wrapping
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state    <= IDLE;
            owner    <= OWN_W'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                owner    <= pick;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    // count owner-ready cycles blocked by a full FIFO, saturating
    always_ff @(posedge wr_clk) begin
        if (wr_rst || stall_clr)
            stall_cnt <= '0;
        else if (state == BURST && req[owner] && fifo_full && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule
